// File: rtl/maxpool_seq_ctrl_if.sv
// Bus bundle between the max-pool sequencer, the feature RAM read port and the pool RAM write port.
// The sequencer takes the slave view; the surrounding environment takes the master view.
interface maxpool_seq_ctrl_if #(
    parameter int CH_W  = 4,
    parameter int FM_AW = 8,
    parameter int PL_AW = 7
);
    logic             start;
    logic [CH_W-1:0]  ch_num;
    logic             busy;
    logic             done;
    logic             fm_rd_en;
    logic [FM_AW-1:0] fm_rd_addr;
    logic [191:0]     fm_rd_data;
    logic             pl_wr_en;
    logic             pl_wr_ready;
    logic [PL_AW-1:0] pl_wr_addr;
    logic [95:0]      pl_wr_data;

    modport slave (
        input  start, ch_num, fm_rd_data, pl_wr_ready,
        output busy, done, fm_rd_en, fm_rd_addr, pl_wr_en, pl_wr_addr, pl_wr_data
    );

    modport master (
        output start, ch_num, fm_rd_data, pl_wr_ready,
        input  busy, done, fm_rd_en, fm_rd_addr, pl_wr_en, pl_wr_addr, pl_wr_data
    );
endinterface

// File: rtl/maxpool_seq_ctrl.sv
// Per channel: load a 24x24x8 map row by row, pool it 2x2 in one cycle, store 12 pooled rows.
// Define MAXPOOL_RELU_EN to zero pooled bytes with bit7 set on write; timing is identical either way.
module maxpool_seq_ctrl #(
    parameter int MAX_CH = 8,
    parameter int FM_AW  = 8,
    parameter int PL_AW  = 7,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    maxpool_seq_ctrl_if.slave bus
);
    localparam int CH_W      = $clog2(MAX_CH + 1);
    localparam int LOAD_LAST = 23 + RD_LAT;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_POOL, S_STORE, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CH_W-1:0]   r_ch;
    logic [CH_W-1:0]   r_ch_last;
    logic [CH_W-1:0]   w_ch_clamp;
    logic [4:0]        r_cnt;
    logic [3:0]        r_wr_row;
    logic [24*192-1:0] r_shadow;
    logic [12*96-1:0]  r_pool;
    logic [12*96-1:0]  w_pool;
    logic              w_load_last;
    logic              w_wr_hs;
    logic              w_row_last;

    function automatic logic [95:0] f_relu(input logic [95:0] d);
`ifdef MAXPOOL_RELU_EN
        for (int i = 0; i < 12; i++)
            f_relu[i*8 +: 8] = d[i*8+7] ? 8'h00 : d[i*8 +: 8];
`else
        f_relu = d;
`endif
    endfunction

    assign w_ch_clamp  = (bus.ch_num > CH_W'(MAX_CH)) ? CH_W'(MAX_CH) : bus.ch_num;
    assign w_load_last = (r_cnt == 5'(LOAD_LAST));
    assign w_wr_hs     = (r_state == S_STORE) && bus.pl_wr_ready;
    assign w_row_last  = (r_wr_row == 4'd11);

    for (genvar r = 0; r < 12; r++) begin : g_row
        for (genvar c = 0; c < 12; c++) begin : g_col
            logic [7:0] w_a, w_b, w_c, w_d, w_m0, w_m1;
            assign w_a  = r_shadow[(2*r)*192   + (2*c)*8   +: 8];
            assign w_b  = r_shadow[(2*r)*192   + (2*c+1)*8 +: 8];
            assign w_c  = r_shadow[(2*r+1)*192 + (2*c)*8   +: 8];
            assign w_d  = r_shadow[(2*r+1)*192 + (2*c+1)*8 +: 8];
            assign w_m0 = (w_a > w_b) ? w_a : w_b;
            assign w_m1 = (w_c > w_d) ? w_c : w_d;
            assign w_pool[r*96 + c*8 +: 8] = (w_m0 > w_m1) ? w_m0 : w_m1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = (bus.ch_num == '0) ? S_DONE : S_LOAD;
            S_LOAD:  if (w_load_last) w_next = S_POOL;
            S_POOL:  w_next = S_STORE;
            S_STORE: if (w_wr_hs && w_row_last) w_next = (r_ch == r_ch_last) ? S_DONE : S_LOAD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.fm_rd_en   = 1'b0;
        bus.fm_rd_addr = '0;
        bus.pl_wr_en   = 1'b0;
        bus.pl_wr_addr = '0;
        bus.pl_wr_data = '0;
        case (r_state)
            S_LOAD: begin
                bus.busy = 1'b1;
                if (r_cnt < 5'd24) begin
                    bus.fm_rd_en   = 1'b1;
                    bus.fm_rd_addr = FM_AW'(r_ch) * FM_AW'(24) + FM_AW'(r_cnt);
                end
            end
            S_POOL:  bus.busy = 1'b1;
            S_STORE: begin
                bus.busy       = 1'b1;
                bus.pl_wr_en   = 1'b1;
                bus.pl_wr_addr = PL_AW'(r_ch) * PL_AW'(12) + PL_AW'(r_wr_row);
                bus.pl_wr_data = f_relu(r_pool[int'(r_wr_row)*96 +: 96]);
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // r_cnt doubles as the issue row (first 24 cycles) and, delayed by RD_LAT, the capture row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch      <= '0;
            r_ch_last <= '0;
            r_cnt     <= '0;
            r_wr_row  <= '0;
            r_shadow  <= '0;
            r_pool    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_ch      <= '0;
                    r_ch_last <= w_ch_clamp - CH_W'(1);
                    r_cnt     <= '0;
                end
                S_LOAD: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt >= 5'(RD_LAT))
                        r_shadow[(int'(r_cnt) - RD_LAT)*192 +: 192] <= bus.fm_rd_data;
                end
                S_POOL: begin
                    r_pool   <= w_pool;
                    r_wr_row <= '0;
                end
                S_STORE: if (w_wr_hs) begin
                    if (w_row_last) begin
                        r_ch  <= r_ch + CH_W'(1);
                        r_cnt <= '0;
                    end else begin
                        r_wr_row <= r_wr_row + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Scoreboard bench for maxpool_seq_ctrl: stimulus pushes expected reads/writes/done timing,
// a negedge monitor pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_maxpool_seq_ctrl;
    localparam int MAX_CH = 8;
    localparam int FM_AW  = 8;
    localparam int PL_AW  = 7;
    localparam int RD_LAT = 1;
    localparam int CH_W   = $clog2(MAX_CH + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maxpool_seq_ctrl_if #(.CH_W(CH_W), .FM_AW(FM_AW), .PL_AW(PL_AW)) bus();

    maxpool_seq_ctrl #(.MAX_CH(MAX_CH), .FM_AW(FM_AW), .PL_AW(PL_AW), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int t_samp = 0;
    int exp_done = -1;
    int busy_cnt = 0;
    bit done_seen = 1'b0;
    bit stall_on = 1'b0;

    int             q_rd[$];
    logic [PL_AW-1:0] q_wa[$];
    logic [95:0]    q_wd[$];

    logic [191:0] fm_mem [MAX_CH*24];
    logic [191:0] rd_pipe [RD_LAT];

    always @(posedge clk) cyc <= cyc + 1;

    // Feature RAM model with fixed read latency
    always @(posedge clk) begin
        rd_pipe[0] <= bus.fm_rd_en ? fm_mem[bus.fm_rd_addr] : '0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.fm_rd_data  = rd_pipe[RD_LAT-1];
    assign bus.pl_wr_ready = !(stall_on && (cyc - t_samp + 1) >= 30 && (cyc - t_samp + 1) <= 34);

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] px(input int ch, input int row, input int col);
        logic [191:0] w;
        w = fm_mem[ch*24 + row];
        return w[col*8 +: 8];
    endfunction

    function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic fill(input int seed);
        logic [191:0] w;
        for (int ch = 0; ch < MAX_CH; ch++)
            for (int row = 0; row < 24; row++) begin
                for (int col = 0; col < 24; col++)
                    w[col*8 +: 8] = 8'((row*24 + col + ch*seed) % 256);
                fm_mem[ch*24 + row] = w;
            end
    endtask

    task automatic expect_run(input int n, input int extra);
        int nn;
        logic [7:0]  m;
        logic [95:0] d;
        nn = (n > MAX_CH) ? MAX_CH : n;
        for (int ch = 0; ch < nn; ch++) begin
            for (int row = 0; row < 24; row++) q_rd.push_back(ch*24 + row);
            for (int r = 0; r < 12; r++) begin
                for (int c = 0; c < 12; c++) begin
                    m = max2(max2(px(ch, 2*r, 2*c), px(ch, 2*r, 2*c+1)),
                             max2(px(ch, 2*r+1, 2*c), px(ch, 2*r+1, 2*c+1)));
`ifdef MAXPOOL_RELU_EN
                    if (m[7]) m = 8'h00;
`endif
                    d[c*8 +: 8] = m;
                end
                q_wa.push_back(PL_AW'(ch*12 + r));
                q_wd.push_back(d);
            end
        end
        exp_done = 1 + 38*nn + extra;
    endtask

    task automatic launch(input int n);
        busy_cnt  = 0;
        done_seen = 1'b0;
        @(negedge clk);
        bus.ch_num = CH_W'(n);
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        t_samp    = cyc;
        bus.start = 1'b0;
    endtask

    task automatic finish_run();
        for (int i = 0; i < 2000 && !done_seen; i++) @(posedge clk);
        if (!done_seen) chk("done_timeout", 96'(done_seen), 96'(1));
        repeat (3) @(posedge clk);
        chk("rd_queue_drained", 96'(q_rd.size()), 96'(0));
        chk("wr_queue_drained", 96'(q_wa.size()), 96'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, 96'(bus.busy), 96'(0));
        chk({tag, "_done"}, 96'(bus.done), 96'(0));
        chk({tag, "_fm_rd_en"}, 96'(bus.fm_rd_en), 96'(0));
        chk({tag, "_fm_rd_addr"}, 96'(bus.fm_rd_addr), 96'(0));
        chk({tag, "_pl_wr_en"}, 96'(bus.pl_wr_en), 96'(0));
        chk({tag, "_pl_wr_addr"}, 96'(bus.pl_wr_addr), 96'(0));
        chk({tag, "_pl_wr_data"}, bus.pl_wr_data, 96'(0));
    endtask

    // Monitor: compares every DUT-presented read, write and done against the scoreboard
    always @(negedge clk) begin
        int rel;
        if (!rst) begin
            rel = cyc - t_samp + 1;
            if (bus.fm_rd_en) begin
                if (q_rd.size() == 0) chk("unexpected_read", 96'(bus.fm_rd_addr), '1);
                else                  chk("rd_addr", 96'(bus.fm_rd_addr), 96'(q_rd.pop_front()));
            end
            if (bus.pl_wr_en) begin
                if (q_wa.size() == 0) begin
                    chk("unexpected_write", 96'(bus.pl_wr_addr), '1);
                end else if (bus.pl_wr_ready) begin
                    chk("wr_addr", 96'(bus.pl_wr_addr), 96'(q_wa.pop_front()));
                    chk("wr_data", bus.pl_wr_data, q_wd.pop_front());
                end else begin
                    chk("hold_addr", 96'(bus.pl_wr_addr), 96'(q_wa[0]));
                    chk("hold_data", bus.pl_wr_data, q_wd[0]);
                end
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_seen = 1'b1;
                chk("done_cycle", 96'(rel), 96'(exp_done));
                chk("busy_at_done", 96'(bus.busy), 96'(0));
                chk("busy_cycles", 96'(busy_cnt), 96'(exp_done - 1));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [95:0] d0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.ch_num = '0;
        for (int i = 0; i < MAX_CH*24; i++) fm_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // no-op run: done one cycle after start, no RAM traffic
        expect_run(0, 0);
        launch(0);
        finish_run();

        fill(0);
        expect_run(1, 0);
        launch(1);
        finish_run();

        fill(37);
        expect_run(2, 0);
        launch(2);
        finish_run();

        // ready held low for 5 cycles while row 3 is presented
        fill(0);
        stall_on = 1'b1;
        expect_run(1, 5);
        launch(1);
        finish_run();
        stall_on = 1'b0;

        // asynchronous reset mid-run, then a clean full run
        fill(11);
        expect_run(2, 0);
        launch(2);
        repeat (19) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        q_rd.delete();
        q_wa.delete();
        q_wd.delete();
        exp_done = -1;
        @(posedge clk);
        #1;
        check_outputs_zero("midrst_edge");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        chk("no_done_after_reset", 96'(done_seen), 96'(0));
        expect_run(2, 0);
        launch(2);
        finish_run();

        // ReLU boundary: window max 8'h85 and 8'h7F, every other pixel zero
        for (int i = 0; i < MAX_CH*24; i++) fm_mem[i] = '0;
        fm_mem[0][7:0]   = 8'h85;
        fm_mem[1][15:8]  = 8'h10;
        fm_mem[0][23:16] = 8'h7F;
        d0 = '0;
`ifdef MAXPOOL_RELU_EN
        d0[7:0] = 8'h00;
`else
        d0[7:0] = 8'h85;
`endif
        d0[15:8] = 8'h7F;
        for (int i = 0; i < 24; i++) q_rd.push_back(i);
        for (int r = 0; r < 12; r++) begin
            q_wa.push_back(PL_AW'(r));
            q_wd.push_back((r == 0) ? d0 : 96'(0));
        end
        exp_done = 39;
        launch(1);
        finish_run();

        // ch_num above MAX_CH is clamped to MAX_CH channels
        fill(5);
        expect_run(15, 0);
        launch(15);
        finish_run();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
